// File: rtl/if_stage.sv
// Instruction-fetch stage for the IITB-RISC pipeline. It owns the PC, drives
// the combinational instr_mem address and fills the IF/ID pipeline register.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] HALT_WORD = 16'hFFFF,
  parameter int unsigned IMEM_SIZE = 200
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic [15:0] ifid_pc_plus1,
  output logic        ifid_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam int unsigned W         = 16;
  localparam logic [W-1:0] CNT_MAX  = W'(16'hFFFF);

  typedef enum logic {RUN, HALT} state_t;

  state_t       r_state,        w_state_nxt;
  logic [W-1:0] r_pc,           w_pc_nxt;
  logic [W-1:0] r_ifid_instr,   w_ifid_instr_nxt;
  logic [W-1:0] r_ifid_pc,      w_ifid_pc_nxt;
  logic [W-1:0] r_ifid_pc_p1,   w_ifid_pc_p1_nxt;
  logic         r_ifid_valid,   w_ifid_valid_nxt;
  logic         r_halted,       w_halted_nxt;
  logic [W-1:0] r_fetch_count,  w_fetch_count_nxt;

  logic [W-1:0] w_fw;
  logic         w_is_halt;
  logic [W-1:0] w_pc_plus1;

  // Addresses beyond the populated ROM read as the halt terminator.
  assign w_fw       = (32'(r_pc) < IMEM_SIZE) ? imem_data : HALT_WORD;
  assign w_is_halt  = (w_fw == HALT_WORD);
  assign w_pc_plus1 = r_pc + W'(1);

  // Next-state and next-register logic; redirect outranks stall and halt.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_ifid_instr_nxt  = r_ifid_instr;
    w_ifid_pc_nxt     = r_ifid_pc;
    w_ifid_pc_p1_nxt  = r_ifid_pc_p1;
    w_ifid_valid_nxt  = r_ifid_valid;
    w_halted_nxt      = r_halted;
    w_fetch_count_nxt = r_fetch_count;

    if (redirect) begin
      w_pc_nxt         = redirect_pc;
      w_ifid_valid_nxt = 1'b0;
      w_ifid_instr_nxt = '0;
      w_halted_nxt     = 1'b0;
      w_state_nxt      = RUN;
    end else if (!stall) begin
      unique case (r_state)
        RUN: begin
          w_ifid_instr_nxt  = w_fw;
          w_ifid_pc_nxt     = r_pc;
          w_ifid_pc_p1_nxt  = w_pc_plus1;
          w_ifid_valid_nxt  = 1'b1;
          w_fetch_count_nxt = (r_fetch_count == CNT_MAX) ? r_fetch_count
                                                         : r_fetch_count + W'(1);
          if (w_is_halt) begin
            w_halted_nxt = 1'b1;
            w_state_nxt  = HALT;
          end else begin
            w_pc_nxt = w_pc_plus1;
          end
        end
        HALT: begin
          w_ifid_valid_nxt = 1'b0;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_ifid_instr  <= '0;
      r_ifid_pc     <= '0;
      r_ifid_pc_p1  <= '0;
      r_ifid_valid  <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_ifid_instr  <= w_ifid_instr_nxt;
      r_ifid_pc     <= w_ifid_pc_nxt;
      r_ifid_pc_p1  <= w_ifid_pc_p1_nxt;
      r_ifid_valid  <= w_ifid_valid_nxt;
      r_halted      <= w_halted_nxt;
      r_fetch_count <= w_fetch_count_nxt;
    end
  end

  // imem_addr is the PC register itself, never a separate copy.
  assign imem_addr     = r_pc;
  assign pc            = r_pc;
  assign ifid_instr    = r_ifid_instr;
  assign ifid_pc       = r_ifid_pc;
  assign ifid_pc_plus1 = r_ifid_pc_p1;
  assign ifid_valid    = r_ifid_valid;
  assign halted        = r_halted;
  assign fetch_count   = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID snapshots are queued as each
// step is driven and compared after the following clock edge.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_plus1;
  logic        ifid_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] rom [256];

  typedef struct {
    string       tag;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic [15:0] ipc1;
    logic        v;
    logic        h;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  if_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  assign imem_data = rom[imem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld,
                     input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
  endtask

  task automatic push(input string tag, input logic [15:0] e_pc,
                      input logic [15:0] e_instr, input logic [15:0] e_ipc,
                      input logic [15:0] e_ipc1, input logic e_v,
                      input logic e_h, input logic [15:0] e_cnt);
    exp_t e;
    e.tag = tag; e.pc = e_pc; e.instr = e_instr; e.ipc = e_ipc;
    e.ipc1 = e_ipc1; e.v = e_v; e.h = e_h; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard_underflow observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "pc",         pc,              e.pc);
    chk(e.tag, "imem_addr",  imem_addr,       e.pc);
    chk(e.tag, "ifid_instr", ifid_instr,      e.instr);
    chk(e.tag, "ifid_pc",    ifid_pc,         e.ipc);
    chk(e.tag, "ifid_pc_p1", ifid_pc_plus1,   e.ipc1);
    chk(e.tag, "ifid_valid", 16'(ifid_valid), 16'(e.v));
    chk(e.tag, "halted",     16'(halted),     16'(e.h));
    chk(e.tag, "fetch_cnt",  fetch_count,     e.cnt);
  endtask

  // One clock: queue the expectation, take the edge, compare just after it.
  task automatic step(input string tag, input logic [15:0] e_pc,
                      input logic [15:0] e_instr, input logic [15:0] e_ipc,
                      input logic [15:0] e_ipc1, input logic e_v,
                      input logic e_h, input logic [15:0] e_cnt);
    push(tag, e_pc, e_instr, e_ipc, e_ipc1, e_v, e_h, e_cnt);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333;
    rom[3] = 16'h4444; rom[4] = 16'h5555; rom[5] = 16'h6666;
    rom[6] = 16'hFFFF;
    for (int i = 7; i < 256; i++) rom[i] = 16'hA000 + 16'(i);

    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    #1 rst = 1'b1;
    #2;
    push("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    check_front();
    @(negedge clk);
    rst = 1'b0;

    // Straight-line fetch up to the terminator at address 6
    step("fetch0", 16'd1, 16'h1111, 16'd0, 16'd1, 1'b1, 1'b0, 16'd1);
    step("fetch1", 16'd2, 16'h2222, 16'd1, 16'd2, 1'b1, 1'b0, 16'd2);
    step("fetch2", 16'd3, 16'h3333, 16'd2, 16'd3, 1'b1, 1'b0, 16'd3);
    step("fetch3", 16'd4, 16'h4444, 16'd3, 16'd4, 1'b1, 1'b0, 16'd4);
    step("fetch4", 16'd5, 16'h5555, 16'd4, 16'd5, 1'b1, 1'b0, 16'd5);
    step("fetch5", 16'd6, 16'h6666, 16'd5, 16'd6, 1'b1, 1'b0, 16'd6);
    step("halt_in", 16'd6, 16'hFFFF, 16'd6, 16'd7, 1'b1, 1'b1, 16'd7);
    step("bubble0", 16'd6, 16'hFFFF, 16'd6, 16'd7, 1'b0, 1'b1, 16'd7);
    step("bubble1", 16'd6, 16'hFFFF, 16'd6, 16'd7, 1'b0, 1'b1, 16'd7);

    // Redirect cancels the halt
    redirect = 1'b1; redirect_pc = 16'h0002;
    step("unhalt", 16'd2, 16'h0000, 16'd6, 16'd7, 1'b0, 1'b0, 16'd7);
    redirect = 1'b0;
    step("refetch2", 16'd3, 16'h3333, 16'd2, 16'd3, 1'b1, 1'b0, 16'd8);

    // Three-cycle stall at pc=3
    stall = 1'b1;
    step("stall0", 16'd3, 16'h3333, 16'd2, 16'd3, 1'b1, 1'b0, 16'd8);
    step("stall1", 16'd3, 16'h3333, 16'd2, 16'd3, 1'b1, 1'b0, 16'd8);
    step("stall2", 16'd3, 16'h3333, 16'd2, 16'd3, 1'b1, 1'b0, 16'd8);
    stall = 1'b0;
    step("resume", 16'd4, 16'h4444, 16'd3, 16'd4, 1'b1, 1'b0, 16'd9);

    // Redirect wins over a simultaneous stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0041;
    step("redir_stall", 16'h0041, 16'h0000, 16'd3, 16'd4, 1'b0, 1'b0, 16'd9);
    stall = 1'b0; redirect = 1'b0;
    step("tgt41", 16'h0042, 16'hA041, 16'h0041, 16'h0042, 1'b1, 1'b0, 16'd10);

    // Out-of-range PC reads as the terminator
    redirect = 1'b1; redirect_pc = 16'd200;
    step("redir200", 16'd200, 16'h0000, 16'h0041, 16'h0042, 1'b0, 1'b0, 16'd10);
    redirect = 1'b0;
    step("oor_halt", 16'd200, 16'hFFFF, 16'd200, 16'd201, 1'b1, 1'b1, 16'd11);
    stall = 1'b1;
    step("halt_stall", 16'd200, 16'hFFFF, 16'd200, 16'd201, 1'b1, 1'b1, 16'd11);
    stall = 1'b0;
    step("halt_bub", 16'd200, 16'hFFFF, 16'd200, 16'd201, 1'b0, 1'b1, 16'd11);

    // Run to pc=5 then assert reset between edges
    redirect = 1'b1; redirect_pc = 16'h0000;
    step("redir0", 16'd0, 16'h0000, 16'd200, 16'd201, 1'b0, 1'b0, 16'd11);
    redirect = 1'b0;
    step("run0", 16'd1, 16'h1111, 16'd0, 16'd1, 1'b1, 1'b0, 16'd12);
    step("run1", 16'd2, 16'h2222, 16'd1, 16'd2, 1'b1, 1'b0, 16'd13);
    step("run2", 16'd3, 16'h3333, 16'd2, 16'd3, 1'b1, 1'b0, 16'd14);
    step("run3", 16'd4, 16'h4444, 16'd3, 16'd4, 1'b1, 1'b0, 16'd15);
    step("run4", 16'd5, 16'h5555, 16'd4, 16'd5, 1'b1, 1'b0, 16'd16);
    #2 rst = 1'b1;
    #1;
    push("async_rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'd0);
    check_front();
    #2 rst = 1'b0;
    step("post_rst", 16'd1, 16'h1111, 16'd0, 16'd1, 1'b1, 1'b0, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
